// File: rtl/ex_bra_resolve_if.sv
// Branch-resolve bundle between the ID/EX pipeline and ex_bra_resolve.
// master drives the ID slot and stall; slave is the resolver.
interface ex_bra_resolve_if;
  localparam int unsigned PC_W  = 48;
  localparam int unsigned CNT_W = 32;

  logic             hold;
  logic             idValid;
  logic [PC_W-1:0]  idBasePc;
  logic [1:0]       idBraKind;
  logic             idPreBra;
  logic [PC_W-1:0]  idPreBraPc;
  logic [PC_W-1:0]  idBraTgtPc;
  logic [PC_W-1:0]  idNextPc;
  logic             exSrT;
  logic [2:0]       exBraDir;
  logic [PC_W-1:0]  exBraBPc;
  logic             exRedirect;
  logic [PC_W-1:0]  exRedirPc;
  logic             exFlush;
  logic [CNT_W-1:0] perfBraCnt;
  logic [CNT_W-1:0] perfMissCnt;

  modport master (
    output hold, idValid, idBasePc, idBraKind, idPreBra, idPreBraPc,
           idBraTgtPc, idNextPc, exSrT,
    input  exBraDir, exBraBPc, exRedirect, exRedirPc, exFlush,
           perfBraCnt, perfMissCnt
  );

  modport slave (
    input  hold, idValid, idBasePc, idBraKind, idPreBra, idPreBraPc,
           idBraTgtPc, idNextPc, exSrT,
    output exBraDir, exBraBPc, exRedirect, exRedirPc, exFlush,
           perfBraCnt, perfMissCnt
  );
endinterface

// File: rtl/ex_bra_resolve.sv
// EX-stage branch resolver: checks the ID prediction against SR.T, redirects and
// squashes wrong-path slots. Define JX2_BRA_PERFCNT_EN for the perf counters.
module ex_bra_resolve #(
  parameter int unsigned FLUSH_CYC = 2
) (
  input logic           clock,
  input logic           reset,
  ex_bra_resolve_if.slave bus
);
  localparam int unsigned PC_W   = 48;
  localparam int unsigned FCNT_W = 2;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] basePc;
    logic [1:0]      kind;
    logic            preBra;
    logic [PC_W-1:0] preBraPc;
    logic [PC_W-1:0] braTgtPc;
    logic [PC_W-1:0] nextPc;
  } ex1Slot_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  ex1Slot_t          ex1;
  state_t            state, stateNext;
  logic [FCNT_W-1:0] flushCnt, flushCntNext;
  logic              taken_c, mispredict_c;
  logic [2:0]        braDir_c;
  logic [PC_W-1:0]   redirPc_c;
  logic [2:0]        exBraDirQ;
  logic [PC_W-1:0]   exBraBPcQ, exRedirPcQ;
  logic              exRedirectQ;

  // EX1 capture; slots entering while flushing are wrong-path and become bubbles
  always_ff @(posedge clock) begin
    if (!reset) begin
      ex1 <= '0;
    end else if (!bus.hold) begin
      ex1 <= '{valid:    bus.idValid && (state != FLUSH),
               basePc:   bus.idBasePc,
               kind:     bus.idBraKind,
               preBra:   bus.idPreBra,
               preBraPc: bus.idPreBraPc,
               braTgtPc: bus.idBraTgtPc,
               nextPc:   bus.idNextPc};
    end
  end

  // Resolution against SR.T
  always_comb begin
    taken_c = 1'b0;
    unique case (ex1.kind)
      2'b00:   taken_c = 1'b1;
      2'b10:   taken_c = bus.exSrT;
      2'b11:   taken_c = !bus.exSrT;
      default: taken_c = 1'b0;
    endcase
    if (!ex1.valid) taken_c = 1'b0;
    mispredict_c = ex1.valid &&
                   ((taken_c != ex1.preBra) ||
                    (taken_c && (ex1.preBraPc != ex1.braTgtPc)));
    redirPc_c    = taken_c ? ex1.braTgtPc : ex1.nextPc;
    braDir_c     = ex1.valid ? {!taken_c, ex1.kind} : 3'b001;
  end

  // EX2 result register feeding front end and predictor
  always_ff @(posedge clock) begin
    if (!reset) begin
      exBraDirQ   <= 3'b001;
      exBraBPcQ   <= '0;
      exRedirectQ <= 1'b0;
      exRedirPcQ  <= '0;
    end else if (!bus.hold) begin
      exBraDirQ   <= braDir_c;
      exBraBPcQ   <= ex1.basePc;
      exRedirectQ <= mispredict_c;
      exRedirPcQ  <= redirPc_c;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= RUN;
      flushCnt <= '0;
    end else begin
      state    <= stateNext;
      flushCnt <= flushCntNext;
    end
  end

  // Flush sequencer: enters the cycle after the redirect strobe
  always_comb begin
    stateNext    = state;
    flushCntNext = flushCnt;
    if (!bus.hold) begin
      unique case (state)
        RUN: begin
          if (exRedirectQ) begin
            stateNext    = FLUSH;
            flushCntNext = FCNT_W'(FLUSH_CYC);
          end
        end
        FLUSH: begin
          if (flushCnt <= FCNT_W'(1)) begin
            stateNext    = RUN;
            flushCntNext = '0;
          end else begin
            flushCntNext = flushCnt - FCNT_W'(1);
          end
        end
        default: stateNext = RUN;
      endcase
    end
  end

  assign bus.exBraDir   = exBraDirQ;
  assign bus.exBraBPc   = exBraBPcQ;
  assign bus.exRedirect = exRedirectQ;
  assign bus.exRedirPc  = exRedirPcQ;
  assign bus.exFlush    = (state == FLUSH);

`ifdef JX2_BRA_PERFCNT_EN
  logic [31:0] braCnt, missCnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      braCnt  <= '0;
      missCnt <= '0;
    end else if (!bus.hold) begin
      if (ex1.valid && (ex1.kind != 2'b01)) braCnt <= braCnt + 32'd1;
      if (mispredict_c) missCnt <= missCnt + 32'd1;
    end
  end

  assign bus.perfBraCnt  = braCnt;
  assign bus.perfMissCnt = missCnt;
`else
  assign bus.perfBraCnt  = '0;
  assign bus.perfMissCnt = '0;
`endif
endmodule

// File: doc/ex_bra_resolve.md
# ex_bra_resolve

Execute-stage branch resolver and misprediction recovery unit. It sits at the far end of the early-branch path: it takes the ID-stage prediction (`preIsBra`/`preBraPc`) and the branch kind, and resolves each branch against the SR.T flag in EX. It generates the redirect/flush for the front end. It also produces the `exBraDir`/`exBraBPc` update stream that the pre-branch predictor consumes to train its counters and history.

## Interface
Parameters:
- `FLUSH_CYC`, default 2: number of advancing cycles of wrong-path slots squashed after a redirect (1..3).

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; state clears on a rising edge with `reset`==0.
- `hold`  in  1  pipeline stall; when 1, no stage register or FSM advances.
- `idValid`  in  1  ID slot holds a real instruction.
- `idBasePc`  in  48  PC of the ID instruction.
- `idBraKind`  in  2  00 unconditional, 01 not a branch, 10 branch-if-T, 11 branch-if-F.
- `idPreBra`  in  1  front end already redirected (predicted taken).
- `idPreBraPc`  in  48  predicted target used by the front end.
- `idBraTgtPc`  in  48  architectural target (disp-computed, or LR for RTSU).
- `idNextPc`  in  48  fall-through PC.
- `exSrT`  in  1  SR.T as seen by the EX1 instruction.
- `exBraDir`  out  3  [1:0] kind, [2]=1 when the branch was not taken; 3'b001 for idle/squashed slots.
- `exBraBPc`  out  48  PC of the resolved instruction.
- `exRedirect`  out  1  one-cycle redirect strobe.
- `exRedirPc`  out  48  corrected fetch PC, valid with `exRedirect`.
- `exFlush`  out  1  kill younger ID/IF slots this cycle.
- `perfBraCnt`, `perfMissCnt`  out  32 each  performance counters (see Configuration).

## Operation
- EX1 register: captures the `id*` inputs when `hold`==0. `idValid` is forced to 0 on capture when `exFlush`==1.
- Taken in EX1:
  - kind 00 → 1
  - kind 10 → `exSrT`
  - kind 11 → !`exSrT`
  - kind 01 → 0
  - invalid slot → 0 with no update.
- Mispredict (valid slot only), any of:
  - taken && !preBra
  - !taken && preBra
  - taken && preBra && `idPreBraPc` != `idBraTgtPc` (full 48-bit compare)
- Redirect PC is `idBraTgtPc` if taken, else `idNextPc`.
- EX2 register (advances when `hold`==0):
  - `exBraDir` = {!taken, kind}, or 3'b001 if the slot is invalid.
  - `exBraBPc` = PC.
  - `exRedirect` = mispredict.
  - `exRedirPc` = redirect PC.
- FSM states: RUN, FLUSH.
  - RUN→FLUSH when a mispredict is registered into EX2; a counter loads `FLUSH_CYC`.
  - In FLUSH, `exFlush`=1 and the counter decrements on each non-held cycle. FLUSH→RUN when it reaches 0.
  - A mispredict on a squashed slot is impossible, because squashed slots are invalid.
- Simultaneous events:
  - `hold` during FLUSH: counter frozen, `exFlush` stays 1.
  - `exRedirect` is a strobe. It lasts one non-held cycle and is held (not repeated) while `hold`==1.
- Reset values:
  - `exBraDir`=3'b001
  - `exBraBPc`=0
  - `exRedirect`=0
  - `exRedirPc`=0
  - `exFlush`=0
  - FSM=RUN
  - counters=0
  - EX1 valid=0
- Reset mid-FLUSH: returns to RUN in the same edge.

## Timing
- Latency: ID capture at edge N, resolution in EX1 during N..N+1, outputs visible after edge N+1 (1 cycle from EX1 entry).
- `exFlush` asserts the cycle after `exRedirect` rises and lasts `FLUSH_CYC` non-held cycles.
- The predictor samples `exBraDir`/`exBraBPc` every cycle. 3'b001 is a guaranteed no-op there.

## Configuration
- `JX2_BRA_PERFCNT_EN` defined:
  - `perfBraCnt` increments per valid EX1 slot with kind != 01.
  - `perfMissCnt` increments per mispredict.
  - Both are 32-bit, wrap modulo 2^32, advance only when `hold`==0, and clear on reset.
- Macro undefined: both outputs are constant 0 and no counter flops are instantiated.

## Test plan
- Reset: hold `reset`=0 for 2 edges → all outputs at reset values, `exBraDir`=001.
- BT predicted taken, `exSrT`=1, preBraPc==tgt=0x1040 → `exBraDir`=3'b010, `exRedirect`=0, no flush.
- BF predicted taken, `exSrT`=1 → `exBraDir`=3'b111, `exRedirect`=1, `exRedirPc`=`idNextPc` (0x1006), `exFlush` high 2 cycles, the next 2 ID slots are emitted as 001.
- Unconditional predicted with preBraPc=0x2000, tgt=0x2010 → redirect to 0x2010, `exBraDir`=3'b000.
- Mispredict then `hold`=1 for 3 cycles in FLUSH → `exFlush` stays 1 across the hold, drops after 2 further non-held cycles. Asserting `reset`=0 mid-FLUSH instead → RUN next edge.
- Macro on: 5 branches (2 mispredicted) plus 3 non-branches → perfBraCnt=5, perfMissCnt=2. Preload perfBraCnt to 0xFFFFFFFF (force) + 1 branch → 0.
